wb_burst_master: RTL and testbench
==================================

# wb_burst_master

Wishbone B3 initiator that turns simple command/stream requests into linear incrementing bursts (CTI 010 / 111) on the shared 32-bit Wishbone bus. It is the active end of the registered-feedback protocol the main RAM and UART answer. It gives non-CPU agents (boot preloader, memory test engine, future DMA) a master port on the interconnect next to the CPU and debug masters. All bus outputs are registered.

## Interface
- AW, 32, address width
- DW, 32, data width (fixed 32; sel_o always 4'hf)
- LEN_BITS, 4, burst length field width; max burst 2**LEN_BITS beats
- wb_clk_i  in  1  clock, all logic rising-edge
- wb_rst_n_i  in  1  reset; one clock, synchronous, active-low
- cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake
- cmd_we_i  in  1  1 = write burst, 0 = read burst
- cmd_adr_i  in  AW  start byte address; bits [1:0] ignored (forced 0)
- cmd_len_i  in  LEN_BITS  beats minus one
- wdat_i / wvalid_i / wready_o  in/in/out  DW/1/1  write data stream
- rdat_o / rvalid_o  out  DW/1  read data stream, no backpressure
- done_o  out  1  one-cycle pulse at command completion
- err_o  out  1  valid with done_o: burst aborted
- wbm_adr_o, wbm_dat_o  out  AW, DW  bus address / write data
- wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o  out  4,1,1,1
- wbm_cti_o, wbm_bte_o  out  3, 2  bte_o always 2'b00 (linear)
- wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i  in  DW,1,1,1

## Operation
- FSM states:
  - IDLE: cmd_ready_o=1. On accept, latch we, adr, len, beat counter = len, then go to BUS.
  - BUS: cyc_o=1. On last-beat ack, or on err_i/rty_i, go to DONE.
  - DONE: done_o=1, cyc_o=stb_o=0. Always returns to IDLE next cycle.
- CTI per beat:
  - len=0: 000 (classic single).
  - len>0: 010 on every beat except the last, 111 on the last.
- Address: adr_o += 4 on each ack, 32-bit wrap from 0xFFFFFFFC to 0x0. No 1 KB boundary check.
- Read beats: each ack drives rdat_o <= dat_i and rvalid_o=1 for exactly one cycle. The consumer must always accept.
- Write data register:
  - wready_o = BUS & we & (beats_loaded <= len) & (!dreg_valid | ack_i).
  - stb_o=1 only while dreg_valid. If wvalid_i is low, stb_o drops (master wait state) and cyc_o stays 1.
- Errors:
  - err_i or rty_i ends the cycle at once: cyc_o, stb_o low next edge; done_o=1 and err_o=1 in DONE.
  - rty is not retried.
  - Write words not yet loaded are not consumed; the producer must flush.
- Reset mid-burst: cyc_o, stb_o drop at the reset edge with no done_o. Latched command and counters are discarded.
- Simultaneous ack_i and err_i: err wins; that beat is not delivered or counted.

## Timing
- Reset values (after reset edge):
  - state IDLE, cmd_ready_o=1.
  - cyc_o, stb_o, we_o, rvalid_o, done_o, err_o, wready_o = 0.
  - adr_o, dat_o, rdat_o = 0; cti_o=000; bte_o=00; sel_o=4'hf.
- Read command accepted at edge N: cyc_o, stb_o high from N+1. Ack at edge M gives rdat_o/rvalid_o at M+1 and next address at M+1.
- Back-to-back acks give 1 beat/cycle; an L-beat read with zero-wait slave has cyc_o high L cycles.
- Write: stb_o rises the cycle after the first word is loaded (earliest N+2).
- done_o is the cycle after the final ack/err. cmd_ready_o returns the cycle after done_o.
- Minimum command-to-command spacing: L+3 cycles.

## Configuration
- WB_BURST_MASTER_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles with stb_o=1 and no ack/err/rty, and clears on any of them.
  - At 255 it aborts exactly like err_i (done_o+err_o).
- Undefined: no watchdog; the master waits forever for a response.

## Test plan
- Read len=3 @0x100, RAM prefilled 0xA0..0xA3, zero wait: cti 010,010,010,111; adr 0x100..0x10C; rdat_o A0..A3 on 4 consecutive cycles; done_o once, err_o=0.
- Write len=0 @0x203 with wdat 0xDEADBEEF: adr_o=0x200, cti 000, sel f; readback via read cmd returns 0xDEADBEEF.
- Write len=7 with wvalid_i low 2 cycles before beat 4: stb_o low exactly 2 cycles, cyc_o stays high, RAM holds all 8 words in order.
- err_i at beat 2 of a len=5 read: 2 rvalid pulses, cyc_o low next edge, done_o+err_o=1; next command accepted normally.
- Reset asserted mid-write burst: cyc_o/stb_o 0 at reset edge, no done_o, cmd_ready_o=1 after release.
- TIMEOUT_EN, slave never acks: done_o+err_o exactly 256 cycles after stb_o rises; without macro, cyc_o still high after 1000 cycles.

Source files
------------

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 initiator issuing linear incrementing bursts.
// Optional response watchdog: define WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LEN_BITS = 4
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_n_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic                cmd_we_i,
   input  logic [AW-1:0]       cmd_adr_i,
   input  logic [LEN_BITS-1:0] cmd_len_i,
   input  logic [DW-1:0]       wdat_i,
   input  logic                wvalid_i,
   output logic                wready_o,
   output logic [DW-1:0]       rdat_o,
   output logic                rvalid_o,
   output logic                done_o,
   output logic                err_o,
   output logic [AW-1:0]       wbm_adr_o,
   output logic [DW-1:0]       wbm_dat_o,
   output logic [3:0]          wbm_sel_o,
   output logic                wbm_we_o,
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic [2:0]          wbm_cti_o,
   output logic [1:0]          wbm_bte_o,
   input  logic [DW-1:0]       wbm_dat_i,
   input  logic                wbm_ack_i,
   input  logic                wbm_err_i,
   input  logic                wbm_rty_i
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   state_t              state;
   state_t              state_n;
   logic [LEN_BITS-1:0] len_q;
   logic [LEN_BITS-1:0] beats;
   logic [LEN_BITS:0]   loaded;
   logic                accept;
   logic                any_rsp;
   logic                ack_ok;
   logic                abort;
   logic                last;
   logic                load;
   logic                timeout;

   assign wbm_sel_o   = 4'hf;
   assign wbm_bte_o   = 2'b00;
   assign cmd_ready_o = (state == IDLE);
   assign accept      = (state == IDLE) & cmd_valid_i;
   assign any_rsp     = wbm_ack_i | wbm_err_i | wbm_rty_i;
   assign ack_ok      = wbm_stb_o & wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;
   assign abort       = wbm_stb_o & (wbm_err_i | wbm_rty_i | timeout);
   assign last        = (beats == '0);

   // Write holding register refills on the same cycle its word is acked
   assign wready_o = (state == BUS) & wbm_we_o
                   & (loaded <= {1'b0, len_q})
                   & (~wbm_stb_o | ack_ok);
   assign load     = wready_o & wvalid_i;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
   logic [7:0] wd;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         wd <= 8'd0;
      end else if (!wbm_stb_o || any_rsp) begin
         wd <= 8'd0;
      end else begin
         wd <= wd + 8'd1;
      end
   end

   assign timeout = wbm_stb_o & (wd == 8'hff) & ~any_rsp;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (cmd_valid_i) state_n = BUS;
         BUS:  if (abort || (ack_ok && last)) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         len_q     <= '0;
         beats     <= '0;
         loaded    <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_we_o  <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_cti_o <= CTI_CLASSIC;
         rdat_o    <= '0;
         rvalid_o  <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         rvalid_o <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         if (accept) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i & ~AW'(3);
            len_q     <= cmd_len_i;
            beats     <= cmd_len_i;
            loaded    <= '0;
            wbm_cti_o <= (cmd_len_i == '0) ? CTI_CLASSIC : CTI_INCR;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= ~cmd_we_i;
         end
         if (state == BUS) begin
            if (ack_ok) begin
               wbm_adr_o <= wbm_adr_o + AW'(4);
               if (!last) beats <= beats - 1'b1;
               if (beats == LEN_BITS'(1)) wbm_cti_o <= CTI_END;
               if (!wbm_we_o) begin
                  rdat_o   <= wbm_dat_i;
                  rvalid_o <= 1'b1;
               end
            end
            if (wbm_we_o) begin
               if (load) begin
                  wbm_dat_o <= wdat_i;
                  wbm_stb_o <= 1'b1;
                  loaded    <= loaded + 1'b1;
               end else if (ack_ok) begin
                  wbm_stb_o <= 1'b0;
               end
            end
            if (state_n == DONE) begin
               wbm_cyc_o <= 1'b0;
               wbm_stb_o <= 1'b0;
               wbm_we_o  <= 1'b0;
               wbm_cti_o <= CTI_CLASSIC;
               done_o    <= 1'b1;
               err_o     <= abort;
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: vector table plus scoreboard for wb_burst_master.
// Watchdog expectations follow WB_BURST_MASTER_TIMEOUT_EN.
module tb_wb_burst_master;

   typedef logic [73:0] w_t;

   typedef struct {
      logic [31:0] adr;
      logic [2:0]  cti;
      logic        we;
      logic [31:0] dat;
   } beat_t;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  len;
      logic [31:0] seed;
      int          gap_at;
      logic [31:0] exp_adr0;
      int          exp_cyc;
      int          exp_stbl;
   } vec_t;

   logic        clk = 1'b0;
   logic        wb_rst_n_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_we_i;
   logic [31:0] cmd_adr_i;
   logic [3:0]  cmd_len_i;
   logic [31:0] wdat_i;
   logic        wvalid_i;
   logic        wready_o;
   logic [31:0] rdat_o;
   logic        rvalid_o;
   logic        done_o;
   logic        err_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
   logic        wbm_err_i;
   logic        wbm_rty_i;

   always #5 clk = ~clk;

   wb_burst_master #(.AW(32), .DW(32), .LEN_BITS(4)) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (wb_rst_n_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_adr_i   (cmd_adr_i),
      .cmd_len_i   (cmd_len_i),
      .wdat_i      (wdat_i),
      .wvalid_i    (wvalid_i),
      .wready_o    (wready_o),
      .rdat_o      (rdat_o),
      .rvalid_o    (rvalid_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_cti_o   (wbm_cti_o),
      .wbm_bte_o   (wbm_bte_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack_i),
      .wbm_err_i   (wbm_err_i),
      .wbm_rty_i   (wbm_rty_i)
   );

   int          total = 0;
   int          bad = 0;
   beat_t       bus_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] model [0:255];
   vec_t        vt [0:7];

   int ncyc = 0;
   int cyc_cnt = 0;
   int stbl_cnt = 0;
   int done_cnt = 0;
   int rv_cnt = 0;
   bit mon_on = 1'b1;

   // zero-wait slave RAM; word index is adr[9:2]
   logic        hold = 1'b0;
   int          err_at = -1;
   int          sbeat = 0;
   bit          seeded = 1'b0;
   logic [31:0] mem [0:255];
   logic        resp;

   always_comb begin
      resp      = wbm_cyc_o & wbm_stb_o & ~hold;
      wbm_err_i = resp && (sbeat == err_at);
      wbm_ack_i = resp && (sbeat != err_at);
      wbm_dat_i = mem[wbm_adr_o[9:2]];
   end
   assign wbm_rty_i = 1'b0;

   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'(i) + 32'h60;
         seeded <= 1'b1;
      end else if (wbm_ack_i && wbm_we_o) begin
         mem[wbm_adr_o[9:2]] <= wbm_dat_o;
      end
      if (!wbm_cyc_o) sbeat <= 0;
      else if (wbm_ack_i) sbeat <= sbeat + 1;
   end

   task automatic chk(input string nm, input w_t act, input w_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      beat_t e;
      ncyc <= ncyc + 1;
      if (wbm_cyc_o) cyc_cnt <= cyc_cnt + 1;
      if (wbm_cyc_o && !wbm_stb_o) stbl_cnt <= stbl_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      if (rvalid_o) rv_cnt <= rv_cnt + 1;
      if (mon_on && wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
         if (bus_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_extra: ack at adr %0h, none expected", wbm_adr_o);
         end else begin
            e = bus_q.pop_front();
            chk("beat", {wbm_adr_o, wbm_cti_o, wbm_we_o, wbm_sel_o, wbm_bte_o,
                         e.we ? wbm_dat_o : 32'h0},
                        {e.adr, e.cti, e.we, 4'hf, 2'b00, e.dat});
         end
      end
      if (mon_on && rvalid_o) begin
         if (rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_extra: rdat %0h, none expected", rdat_o);
         end else begin
            chk("rdat", w_t'(rdat_o), w_t'(rd_q.pop_front()));
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] adr,
                        input logic [3:0] len);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL cmd_ready: got 0 want 1 within 20 cycles");
      end
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_len_i   = len;
      @(negedge clk);
      cmd_valid_i = 1'b0;
   endtask

   task automatic produce(input logic [31:0] seed, input int len,
                          input int gap_at);
      int k = 0;
      int g = 0;
      for (int c = 0; c < 200 && k <= len; c++) begin
         @(negedge clk);
         if (k == gap_at && g < 2) begin
            wvalid_i = 1'b0;
            g++;
         end else begin
            wvalid_i = 1'b1;
            wdat_i   = seed + 32'(k);
         end
         #1;
         if (wready_o && wvalid_i) k++;
      end
      @(negedge clk);
      wvalid_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output logic er);
      bit seen = 1'b0;
      er = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_o) begin
            seen = 1'b1;
            er   = err_o;
            chk("done_cyc_low", w_t'(wbm_cyc_o), w_t'(0));
            chk("done_ready_low", w_t'(cmd_ready_o), w_t'(0));
            break;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_wait: got no done_o want one within %0d", budget);
      end else begin
         @(negedge clk);
         chk("done_pulse", w_t'(done_o), w_t'(0));
         chk("ready_back", w_t'(cmd_ready_o), w_t'(1));
      end
   endtask

   task automatic run_vec(input vec_t t);
      logic er;
      int   c0 = cyc_cnt;
      int   s0 = stbl_cnt;
      int   d0 = done_cnt;
      for (int i = 0; i <= int'(t.len); i++) begin
         beat_t       b;
         logic [31:0] a;
         a     = t.exp_adr0 + 32'(4 * i);
         b.adr = a;
         b.cti = (t.len == 4'd0) ? 3'b000 :
                 (i == int'(t.len)) ? 3'b111 : 3'b010;
         b.we  = t.we;
         b.dat = t.we ? t.seed + 32'(i) : 32'h0;
         bus_q.push_back(b);
         if (t.we) model[a[9:2]] = t.seed + 32'(i);
         else rd_q.push_back(model[a[9:2]]);
      end
      if (t.we) begin
         fork
            issue(t.we, t.adr, t.len);
            produce(t.seed, int'(t.len), t.gap_at);
         join
      end else begin
         issue(t.we, t.adr, t.len);
      end
      wait_done(200, er);
      chk("err_clear", w_t'(er), w_t'(0));
      chk("cyc_cycles", w_t'(cyc_cnt - c0), w_t'(t.exp_cyc));
      chk("stb_low_cycles", w_t'(stbl_cnt - s0), w_t'(t.exp_stbl));
      chk("done_once", w_t'(done_cnt - d0), w_t'(1));
      chk("q_drain", w_t'(bus_q.size() + rd_q.size()), w_t'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic er;
      int   d0;
      int   r0;
      int   t0;
      int   t1;
      bit   got;
      vec_t nv;

      wb_rst_n_i  = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_adr_i   = '0;
      cmd_len_i   = '0;
      wdat_i      = '0;
      wvalid_i    = 1'b0;
      for (int i = 0; i < 256; i++) model[i] = 32'(i) + 32'h60;

      vt[0] = '{we:1'b0, adr:32'h100, len:4'd3, seed:32'h0, gap_at:-1,
                exp_adr0:32'h100, exp_cyc:4, exp_stbl:0};
      vt[1] = '{we:1'b1, adr:32'h203, len:4'd0, seed:32'hdeadbeef, gap_at:-1,
                exp_adr0:32'h200, exp_cyc:2, exp_stbl:1};
      vt[2] = '{we:1'b0, adr:32'h200, len:4'd0, seed:32'h0, gap_at:-1,
                exp_adr0:32'h200, exp_cyc:1, exp_stbl:0};
      vt[3] = '{we:1'b1, adr:32'h300, len:4'd7, seed:32'h11110000, gap_at:4,
                exp_adr0:32'h300, exp_cyc:11, exp_stbl:3};
      vt[4] = '{we:1'b0, adr:32'h300, len:4'd7, seed:32'h0, gap_at:-1,
                exp_adr0:32'h300, exp_cyc:8, exp_stbl:0};
      vt[5] = '{we:1'b0, adr:32'hfffffffa, len:4'd3, seed:32'h0, gap_at:-1,
                exp_adr0:32'hfffffff8, exp_cyc:4, exp_stbl:0};
      vt[6] = '{we:1'b1, adr:32'h40, len:4'd15, seed:32'h22220000, gap_at:-1,
                exp_adr0:32'h40, exp_cyc:17, exp_stbl:1};
      vt[7] = '{we:1'b0, adr:32'h40, len:4'd15, seed:32'h0, gap_at:-1,
                exp_adr0:32'h40, exp_cyc:16, exp_stbl:0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", w_t'(cmd_ready_o), w_t'(1));
      chk("rst_ctl", w_t'({wbm_cyc_o, wbm_stb_o, wbm_we_o, rvalid_o,
                           done_o, err_o, wready_o}), w_t'(0));
      chk("rst_adr", w_t'(wbm_adr_o), w_t'(0));
      chk("rst_dat", w_t'(wbm_dat_o), w_t'(0));
      chk("rst_rdat", w_t'(rdat_o), w_t'(0));
      chk("rst_cti_bte_sel", w_t'({wbm_cti_o, wbm_bte_o, wbm_sel_o}),
          w_t'({3'b000, 2'b00, 4'hf}));
      wb_rst_n_i = 1'b1;

      for (int v = 0; v < 8; v++) run_vec(vt[v]);

      // bus error on the third beat of a six-beat read
      err_at = 2;
      bus_q.push_back('{adr:32'h100, cti:3'b010, we:1'b0, dat:32'h0});
      bus_q.push_back('{adr:32'h104, cti:3'b010, we:1'b0, dat:32'h0});
      rd_q.push_back(model[8'h40]);
      rd_q.push_back(model[8'h41]);
      r0 = rv_cnt;
      d0 = done_cnt;
      issue(1'b0, 32'h100, 4'd5);
      wait_done(50, er);
      chk("err_flag", w_t'(er), w_t'(1));
      chk("err_rvalid", w_t'(rv_cnt - r0), w_t'(2));
      chk("err_done_once", w_t'(done_cnt - d0), w_t'(1));
      chk("err_q_drain", w_t'(bus_q.size() + rd_q.size()), w_t'(0));
      err_at = -1;
      nv = '{we:1'b0, adr:32'h108, len:4'd1, seed:32'h0, gap_at:-1,
             exp_adr0:32'h108, exp_cyc:2, exp_stbl:0};
      run_vec(nv);

      // reset in the middle of a write burst
      mon_on   = 1'b0;
      d0       = done_cnt;
      wvalid_i = 1'b1;
      wdat_i   = 32'h55550000;
      issue(1'b1, 32'h380, 4'd7);
      repeat (3) @(negedge clk);
      chk("rst_mid_busy", w_t'(wbm_cyc_o), w_t'(1));
      wb_rst_n_i = 1'b0;
      wvalid_i   = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_cyc_stb", w_t'({wbm_cyc_o, wbm_stb_o}), w_t'(0));
      @(negedge clk);
      wb_rst_n_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mid_nodone", w_t'(done_cnt - d0), w_t'(0));
      chk("rst_mid_ready", w_t'(cmd_ready_o), w_t'(1));
      mon_on = 1'b1;

      // slave that never answers
      hold = 1'b1;
      d0   = done_cnt;
      issue(1'b0, 32'h100, 4'd0);
`ifdef WB_BURST_MASTER_TIMEOUT_EN
      got = 1'b0;
      t1  = 0;
      er  = 1'b0;
      chk("wd_stb_up", w_t'(wbm_stb_o), w_t'(1));
      t0 = ncyc;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (done_o) begin
            t1  = ncyc;
            er  = err_o;
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL wd_fire: got no done_o want one after 256 cycles");
      end else begin
         chk("wd_time", w_t'(t1 - t0), w_t'(256));
         chk("wd_err", w_t'(er), w_t'(1));
      end
      @(negedge clk);
      hold = 1'b0;
`else
      repeat (1000) @(negedge clk);
      chk("no_wd_cyc", w_t'(wbm_cyc_o), w_t'(1));
      chk("no_wd_done", w_t'(done_cnt - d0), w_t'(0));
      wb_rst_n_i = 1'b0;
      @(negedge clk);
      wb_rst_n_i = 1'b1;
      hold       = 1'b0;
`endif
      nv = '{we:1'b0, adr:32'h100, len:4'd1, seed:32'h0, gap_at:-1,
             exp_adr0:32'h100, exp_cyc:2, exp_stbl:0};
      run_vec(nv);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
